// File: rtl/rgb_led_cmd_sched.sv
// rtl/rgb_led_cmd_sched.sv - UART-driven RGB LED PWM command scheduler
//
// Accepts two-byte commands ('R'/'G'/'B' then a duty byte) from a UART receiver,
// answers each command with a single response byte ('K' accepted, '?' unknown),
// and drives three PWM LED outputs from double-buffered duty registers.
//
// Ports:
//   clk_100p0  system clock, rising edge
//   rst        synchronous reset, active-high
//   rx_data    received byte, valid while rx_valid is high
//   rx_valid   one-cycle receive strobe
//   tx_data    response byte, stable while tx_valid is high
//   tx_valid   response byte available
//   tx_ready   transmitter accepts tx_data on tx_valid & tx_ready
//   led_r/g/b  PWM outputs, active-high
//   busy       command FSM is not idle
//
// PWM_BITS must not exceed 8, since duty values come from one received byte.

module rgb_led_cmd_sched #(
  parameter int PWM_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_100p0,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GET_VAL = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam logic [7:0] BYTE_R    = 8'h52;
  localparam logic [7:0] BYTE_G    = 8'h47;
  localparam logic [7:0] BYTE_B    = 8'h42;
  localparam logic [7:0] BYTE_ACK  = 8'h4B;
  localparam logic [7:0] BYTE_NACK = 8'h3F;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [1:0]          ch_sel;
  logic [TO_W-1:0]     to_cnt;
  logic                to_expired;
  logic                is_chan;
  logic [1:0]          chan_code;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pend_r, pend_g, pend_b;
  logic [PWM_BITS-1:0] act_r, act_g, act_b;

  always_comb begin
    is_chan   = 1'b1;
    chan_code = CH_R;
    case (rx_data)
      BYTE_R:  chan_code = CH_R;
      BYTE_G:  chan_code = CH_G;
      BYTE_B:  chan_code = CH_B;
      default: is_chan = 1'b0;
    endcase
  end

  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_valid) state_next = is_chan ? GET_VAL : RESP;
      end
      GET_VAL: begin
        // A value byte arriving in the expiry cycle still wins over the timeout.
        if (rx_valid)        state_next = RESP;
        else if (to_expired) state_next = IDLE;
      end
      RESP: begin
        if (tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // busy and tx_valid are registered from the next state so they line up
  // exactly with the state register rather than trailing it by a cycle.
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      ch_sel   <= CH_R;
      to_cnt   <= '0;
      pend_r   <= '0;
      pend_g   <= '0;
      pend_b   <= '0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != IDLE);
      tx_valid <= (state_next == RESP);
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (is_chan) begin
              ch_sel <= chan_code;
              to_cnt <= '0;
            end else begin
              tx_data <= BYTE_NACK;
            end
          end
        end
        GET_VAL: begin
          if (rx_valid) begin
            tx_data <= BYTE_ACK;
            case (ch_sel)
              CH_R:    pend_r <= rx_data[PWM_BITS-1:0];
              CH_G:    pend_g <= rx_data[PWM_BITS-1:0];
              default: pend_b <= rx_data[PWM_BITS-1:0];
            endcase
          end else if (!to_expired) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Active duties only change on the wrap so each PWM period uses one value.
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      pwm_cnt <= '0;
      act_r   <= '0;
      act_g   <= '0;
      act_b   <= '0;
      led_r   <= 1'b0;
      led_g   <= 1'b0;
      led_b   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == {PWM_BITS{1'b1}}) begin
        act_r <= pend_r;
        act_g <= pend_g;
        act_b <= pend_b;
      end
      led_r <= (pwm_cnt < act_r);
      led_g <= (pwm_cnt < act_g);
      led_b <= (pwm_cnt < act_b);
    end
  end

endmodule

// File: tb/tb_rgb_led_cmd_sched.sv
// tb/tb_rgb_led_cmd_sched.sv - self-checking bench for rgb_led_cmd_sched

module tb_rgb_led_cmd_sched;

  localparam int TO_CYC = 16;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       led_r, led_g, led_b;
  logic       busy;
  logic [2:0] leds;

  int checks = 0;
  int errors = 0;

  logic [7:0] chan_byte [3];
  logic [7:0] model_pend [3];
  logic [7:0] exp_q [$];

  rgb_led_cmd_sched #(
    .PWM_BITS(8),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_100p0(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b),
    .busy(busy)
  );

  assign leds = {led_b, led_g, led_r};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // PWM reference: counter = edges since reset mod 256; each period uses the
  // pending duty as it stood when that period began; LED shows it one cycle late.
  initial begin : pwm_model
    int         n;
    int         cval;
    bit         live;
    logic [7:0] act [3];
    logic [7:0] dv [3];
    bit         exp_led [3];
    int         hi [3];
    int         bad [3];
    n = 0;
    live = 0;
    for (int c = 0; c < 3; c++) begin
      act[c] = 0; dv[c] = 0; exp_led[c] = 0; hi[c] = 0; bad[c] = 0;
    end
    cval = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        n = 0;
        live = 0;
        for (int c = 0; c < 3; c++) begin
          act[c] = 0; model_pend[c] = 0; hi[c] = 0; bad[c] = 0;
        end
      end else begin
        cval = n % 256;
        for (int c = 0; c < 3; c++) begin
          dv[c] = act[c];
          exp_led[c] = (cval < int'(act[c]));
        end
        n++;
        if (n % 256 == 0)
          for (int c = 0; c < 3; c++) act[c] = model_pend[c];
        live = 1;
      end
      @(negedge clk);
      if (live) begin
        for (int c = 0; c < 3; c++) begin
          if (leds[c]) hi[c]++;
          if (leds[c] != exp_led[c]) bad[c]++;
          if (cval == 255) begin
            chk($sformatf("led%0d_period_high", c), hi[c], int'(dv[c]));
            chk($sformatf("led%0d_period_shape", c), bad[c], 0);
            hi[c] = 0;
            bad[c] = 0;
          end
        end
      end
    end
  end

  // Every completed handshake must match the next expected response byte.
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_spurious", int'(tx_data), -1);
        else chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] rand_bad_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == 8'h52 || b == 8'h47 || b == 8'h42);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic finish_resp(input logic [7:0] exp, input int hold, input bit inject);
    int inj_at;
    bit seen;
    inj_at = (inject && hold > 0) ? $urandom_range(0, hold - 1) : -1;
    tx_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == inj_at) begin
        rx_data  = ($urandom_range(0, 1) == 0) ? 8'h47 : 8'($urandom_range(0, 255));
        rx_valid = 1'b1;
      end
      @(negedge clk);
      chk("resp_valid_held", int'(tx_valid), 1);
      chk("resp_data_held", int'(tx_data), int'(exp));
      step();
      rx_valid = 1'b0;
    end
    tx_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
      step();
    end
    tx_ready = 1'b0;
    chk("resp_handshake", int'(seen), 1);
    @(negedge clk);
    chk("tx_valid_drop", int'(tx_valid), 0);
    chk("busy_after_resp", int'(busy), 0);
    step();
  endtask

  task automatic cmd(input int c, input logic [7:0] val, input int gap, input int hold,
                     input bit inject);
    exp_q.push_back(8'h4B);
    pulse_rx(chan_byte[c]);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("busy_get_val", int'(busy), 1);
      step();
    end
    pulse_rx(val);
    model_pend[c] = val;
    finish_resp(8'h4B, hold, inject);
  endtask

  task automatic bad_cmd(input logic [7:0] b, input int hold, input bit inject);
    exp_q.push_back(8'h3F);
    pulse_rx(b);
    finish_resp(8'h3F, hold, inject);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : main
    chan_byte[0] = 8'h52;
    chan_byte[1] = 8'h47;
    chan_byte[2] = 8'h42;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx_valid", int'(tx_valid), 0);
    chk("reset_tx_data", int'(tx_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_leds", int'(leds), 0);
    step();

    // red at half duty
    cmd(0, 8'h80, 0, 0, 0);
    idle(600);

    // unknown byte held off for 10 cycles, with a stray 'G' inside the window
    exp_q.push_back(8'h3F);
    pulse_rx(8'h5A);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin rx_data = 8'h47; rx_valid = 1'b1; end
      @(negedge clk);
      chk("hold10_valid", int'(tx_valid), 1);
      chk("hold10_data", int'(tx_data), 8'h3F);
      step();
      rx_valid = 1'b0;
    end
    finish_resp(8'h3F, 0, 0);

    // blue with no value byte: timeout returns to idle silently
    pulse_rx(8'h42);
    for (int i = 0; i < TO_CYC; i++) begin
      @(negedge clk);
      chk("timeout_busy_high", int'(busy), 1);
      chk("timeout_no_tx", int'(tx_valid), 0);
      step();
    end
    @(negedge clk);
    chk("timeout_busy_low", int'(busy), 0);
    step();
    idle(300);

    // green full then zero part-way through a period
    cmd(1, 8'hFF, 1, 1, 0);
    idle(330);
    cmd(1, 8'h00, 0, 2, 0);
    idle(600);

    // red at zero then full duty
    cmd(0, 8'h00, 0, 0, 0);
    idle(300);
    cmd(0, 8'hFF, 2, 0, 0);
    idle(600);

    // reset in GET_VAL: the value byte is then an unknown command
    pulse_rx(8'h52);
    do_reset();
    @(negedge clk);
    chk("rst_getval_busy", int'(busy), 0);
    step();
    bad_cmd(8'h40, 1, 0);
    idle(600);

    // reset while a response is pending drops it
    pulse_rx(rand_bad_byte());
    step();
    do_reset();
    @(negedge clk);
    chk("rst_resp_tx_valid", int'(tx_valid), 0);
    chk("rst_resp_tx_data", int'(tx_data), 0);
    chk("rst_resp_busy", int'(busy), 0);
    step();

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 6)
        cmd($urandom_range(0, 2), 8'($urandom_range(0, 255)), $urandom_range(0, 10),
            $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else if (kind < 8)
        bad_cmd(rand_bad_byte(), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else
        idle($urandom_range(0, 300));
    end
    idle(600);

    chk("tx_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_led_cmd_sched.md
RGB_LED_CMD_SCHED -- requirements
Module: rgb_led_cmd_sched

Interface
REQ-001 Parameter PWM_BITS, default 8: width of the PWM counter and of each duty register.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: idle cycles allowed between a channel byte and its value byte.
REQ-003 The block SHALL use one clock and synchronous, active-high reset with the following ports:
- clk_100p0  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- tx_data  out  8  response byte to the UART transmitter
- tx_valid  out  1  response byte available
- tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready
- led_r  out  1  red PWM output, active-high
- led_g  out  1  green PWM output, active-high
- led_b  out  1  blue PWM output, active-high
- busy  out  1  high whenever the FSM is not in IDLE

Function
REQ-004 Command FSM states SHALL be IDLE, GET_VAL and RESP.
REQ-005 In IDLE, an rx_valid with rx_data 0x52 'R', 0x47 'G' or 0x42 'B' SHALL latch the channel select and move to GET_VAL on the next cycle.
REQ-006 In IDLE, an rx_valid with any other byte SHALL load tx_data=0x3F '?' and move to RESP.
REQ-007 In GET_VAL, an rx_valid SHALL write rx_data[PWM_BITS-1:0] into the selected channel's pending duty register, load tx_data=0x4B 'K' and move to RESP.
REQ-008 In GET_VAL, a timeout counter SHALL count cycles without rx_valid.
- At count TIMEOUT_CYCLES-1 the FSM SHALL return to IDLE.
- No duty register is written and no response is sent.
- The counter clears on entry to GET_VAL.
REQ-009 In RESP, tx_valid SHALL be high and tx_data SHALL be held stable until the cycle with tx_ready=1.
- The FSM then returns to IDLE.
- tx_valid deasserts the following cycle.
REQ-010 rx_valid strobes arriving while in RESP SHALL be discarded without side effects.
REQ-011 tx_valid SHALL be low in every state other than RESP.
REQ-012 The PWM counter SHALL be a free-running PWM_BITS-bit up-counter that wraps from 2^PWM_BITS-1 to 0.
REQ-013 The active duty registers SHALL load from the pending duty registers only in the cycle the counter wraps to 0, so a PWM period never mixes two duty values.
REQ-014 Each LED output SHALL be registered as (counter < active_duty) for its channel, giving one cycle of latency from the counter.
- Duty 0 gives a constantly low output.
- Duty 255 (PWM_BITS=8) gives a high output for 255 of every 256 cycles.
REQ-015 busy SHALL be a registered indication that the state is not IDLE.

Reset
REQ-016 On rst=1 at a clock edge, the FSM SHALL go to IDLE, regardless of the current state, including mid-command and mid-RESP.
REQ-017 On reset, the PWM counter, timeout counter, and all pending and active duty registers SHALL clear to 0.
REQ-018 On reset, tx_valid, led_r, led_g, led_b and busy SHALL be 0, and tx_data SHALL be 0x00.
REQ-019 A response pending at reset SHALL be dropped, and a partial command SHALL not write any duty register.

Verification
REQ-020 Send 'R' then 0x80 with tx_ready=1 -> tx byte 0x4B once. From the next counter wrap, led_r is high for 128 of every 256 cycles, and led_g and led_b stay low.
REQ-021 Send 0x5A with tx_ready=0 for 10 cycles -> tx_valid stays high with tx_data=0x3F for all 10 cycles. A 'G' sent during this window is ignored, and the handshake completes on the first tx_ready=1 cycle.
REQ-022 Send 'B' then nothing, with TIMEOUT_CYCLES=16 -> busy falls 16 cycles after GET_VAL entry, no tx_valid pulse occurs, and led_b stays 0.
REQ-023 Write 'G',0xFF, then 'G',0x00 mid-period -> led_g finishes the current 0xFF period and is low from the next wrap. The output never shows a shortened or merged period.
REQ-024 Assert rst while in GET_VAL after 'R', then send 0x40 -> the FSM returns '?' (0x3F) for 0x40 and duty_r remains 0.
REQ-025 Send 'R',0x00 -> led_r is constantly 0. Send 'R',0xFF -> led_r is low exactly when the counter equals 255, delayed by one cycle.
